chess_turn_ctrl: RTL and testbench
==================================

CHESS_TURN_CTRL -- requirements
Module: chess_turn_ctrl

Interface
REQ-001 The block SHALL have parameter p_INCREMENT, default 2, giving the bonus seconds added per completed move (legal range 0..9).
REQ-002 The block SHALL have the following ports, clock and reset first:
- i_clk  input  1  system clock (50 MHz); single clock domain.
- i_rst  input  1  reset; asynchronous assert, active-low.
- i_restart  input  1  restart click, one-cycle pulse.
- i_stop  input  1  pause/resume click, one-cycle pulse.
- i_player_a  input  1  player A clock-button click, one-cycle pulse.
- i_player_b  input  1  player B clock-button click, one-cycle pulse.
- i_player_a_zero  input  1  player A counter reads 00.
- i_player_b_zero  input  1  player B counter reads 00.
- o_player_a_stop  output  1  1 = freeze player A prescaler.
- o_player_b_stop  output  1  1 = freeze player B prescaler.
- o_plus_a  output  1  one-cycle +1 s pulse to player A counter.
- o_plus_b  output  1  one-cycle +1 s pulse to player B counter.
- o_restart  output  1  active-low reload of prescalers and counters.
- o_flag_a  output  1  player A flag fallen.
- o_flag_b  output  1  player B flag fallen.
- o_moves  output  8  completed-move count, binary.

Function
REQ-003 The FSM SHALL have exactly these states: IDLE, RUN_A, RUN_B, PAUSE, FLAG; PAUSE SHALL retain the paused side in a 1-bit register.
REQ-004 In IDLE, both stop outputs SHALL be 1; i_player_a SHALL go to RUN_B and i_player_b SHALL go to RUN_A, with no bonus and no move count.
REQ-005 In RUN_A, o_player_a_stop SHALL be 0 and o_player_b_stop SHALL be 1, and the reverse SHALL hold in RUN_B; both SHALL be 1 in PAUSE and FLAG.
REQ-006 In RUN_A, i_player_a SHALL go to RUN_B, increment o_moves, and queue p_INCREMENT bonus pulses on o_plus_a; RUN_B/i_player_b SHALL act symmetrically.
REQ-007 A click from the non-running player, and simultaneous i_player_a and i_player_b, SHALL be ignored in every state.
REQ-008 i_stop SHALL move RUN_x to PAUSE; in PAUSE it SHALL return to the remembered RUN_x; it SHALL be ignored in IDLE and FLAG; player clicks SHALL be ignored in PAUSE.
REQ-009 In RUN_A, i_player_a_zero SHALL go to FLAG and set o_flag_a; B SHALL act symmetrically. A zero SHALL win over a same-cycle player click or i_stop.
REQ-010 FLAG SHALL be left only by i_restart or reset; o_flag_a and o_flag_b SHALL hold until then.
REQ-011 i_restart SHALL have the highest priority in every state: the next state is IDLE, o_moves clears, flags clear, pending bonus aborts, and o_restart is 0 for exactly one cycle.
REQ-012 Bonus pulses SHALL start the cycle after the accepting click, with one pulse every 2 cycles (pulse, gap), totalling exactly p_INCREMENT; p_INCREMENT = 0 SHALL emit none.
REQ-013 Pending bonus pulses SHALL complete regardless of later PAUSE or FLAG transitions.
REQ-014 A new click accepted while bonus pulses are still pending SHALL add its pulses to the pending total; the total SHALL saturate at 15.
REQ-015 o_moves SHALL saturate at 255.
REQ-016 All outputs SHALL be registered; state changes SHALL appear one cycle after the input pulse.

Reset
REQ-017 While i_rst = 0, the block SHALL be in IDLE with o_player_a_stop = 1, o_player_b_stop = 1, o_plus_a = 0, o_plus_b = 0, o_restart = 0, o_flag_a = 0, o_flag_b = 0, o_moves = 0, and no pending bonus.
REQ-018 o_restart SHALL deassert to 1 on the first clock edge after i_rst releases.

Structure
REQ-019 Package chess_clock_pkg SHALL hold the t_cc_state enum and the bonus-gap constant (2).
REQ-020 Bonus pulse generation SHALL be a sub-module, chess_bonus_seq, instantiated once per player.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Reset, then i_player_a -> RUN_B; o_player_b_stop = 0, o_player_a_stop = 1, o_moves = 0, no o_plus pulses.
- RUN_B, i_player_b, p_INCREMENT = 2 -> RUN_A; o_moves = 1; o_plus_b pulses at +1 and +3 cycles only.
- RUN_A, i_stop, i_stop -> PAUSE (both stops 1), then RUN_A; same-cycle i_player_a ignored while in PAUSE.
- RUN_A, i_player_a_zero with i_player_a in the same cycle -> FLAG; o_flag_a = 1; o_moves unchanged; later clicks ignored.
- FLAG, i_restart -> o_restart = 0 for one cycle; IDLE; flags = 0; o_moves = 0.
- Restart mid-bonus (after 1 of 2 pulses) -> no further o_plus pulses; 256 moves -> o_moves = 255.

Source files
------------

// File: rtl/chess_clock_pkg.sv
// Shared types and constants for the chess clock turn controller.
// Holds the turn-FSM state enum, bonus pulse spacing and a 4-bit saturating add.
// No ports; imported by chess_bonus_seq and chess_turn_ctrl.
package chess_clock_pkg;

  typedef enum logic [2:0] {
    CC_IDLE  = 3'd0,
    CC_RUN_A = 3'd1,
    CC_RUN_B = 3'd2,
    CC_PAUSE = 3'd3,
    CC_FLAG  = 3'd4
  } t_cc_state;

  // Cycles from one bonus pulse to the next (pulse, gap).
  localparam int CC_BONUS_GAP = 2;

  // Largest number of bonus pulses that can be pending at once.
  localparam logic [3:0] CC_BONUS_MAX = 4'd15;

  function automatic logic [3:0] sat_add4(input logic [3:0] a, input logic [3:0] b);
    logic [4:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[4] ? CC_BONUS_MAX : sum[3:0];
  endfunction

endpackage

// File: rtl/chess_bonus_seq.sv
// Bonus-second pulse sequencer for one player: queues p_INCREMENT pulses per accepted move.
// Ports: i_clk/i_rst clock and async active-low reset, i_clear aborts all pending pulses,
// i_add queues one move's worth of pulses, o_plus registered one-cycle +1 s pulse.
module chess_bonus_seq
  import chess_clock_pkg::*;
#(
  parameter int p_INCREMENT = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_add,
  output logic o_plus
);

  localparam logic [3:0] INC = 4'(p_INCREMENT);

  logic [3:0] pend;
  logic [3:0] avail;
  logic [1:0] gap;

  // Pulses newly queued this cycle are counted before deciding whether to emit,
  // so the first pulse appears in the cycle right after the accepting click.
  always_comb begin
    avail = sat_add4(pend, i_add ? INC : 4'd0);
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      pend   <= 4'd0;
      gap    <= 2'd0;
      o_plus <= 1'b0;
    end else if (i_clear) begin
      pend   <= 4'd0;
      gap    <= 2'd0;
      o_plus <= 1'b0;
    end else if (avail != 4'd0 && gap == 2'd0) begin
      o_plus <= 1'b1;
      pend   <= avail - 4'd1;
      gap    <= 2'(CC_BONUS_GAP - 1);
    end else begin
      o_plus <= 1'b0;
      pend   <= avail;
      if (gap != 2'd0) gap <= gap - 2'd1;
    end
  end

endmodule

// File: rtl/chess_turn_ctrl.sv
// Chess clock turn controller: decides which player's clock runs, counts moves, raises flags.
// Inputs: one-cycle click pulses (restart, stop, player A/B) and per-player zero levels.
// Outputs (all registered): prescaler freezes, bonus pulses, active-low reload, flags, move count.
module chess_turn_ctrl
  import chess_clock_pkg::*;
#(
  parameter int p_INCREMENT = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_restart,
  input  logic       i_stop,
  input  logic       i_player_a,
  input  logic       i_player_b,
  input  logic       i_player_a_zero,
  input  logic       i_player_b_zero,
  output logic       o_player_a_stop,
  output logic       o_player_b_stop,
  output logic       o_plus_a,
  output logic       o_plus_b,
  output logic       o_restart,
  output logic       o_flag_a,
  output logic       o_flag_b,
  output logic [7:0] o_moves
);

  t_cc_state state, state_nxt;
  logic      pause_side, pause_side_nxt;  // 0 = A was running, 1 = B was running
  logic      click_a, click_b;
  logic      move_a, move_b;
  logic      flag_a_set, flag_b_set;

  logic       stop_a_nxt, stop_b_nxt, restart_nxt, flag_a_nxt, flag_b_nxt;
  logic [7:0] moves_nxt;

  // A click only counts when the other button is not pressed in the same cycle.
  assign click_a = i_player_a & ~i_player_b;
  assign click_b = i_player_b & ~i_player_a;

  // State and output registers; outputs are computed from the next state so
  // every change is visible one cycle after the input pulse.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state           <= CC_IDLE;
      pause_side      <= 1'b0;
      o_player_a_stop <= 1'b1;
      o_player_b_stop <= 1'b1;
      o_restart       <= 1'b0;
      o_flag_a        <= 1'b0;
      o_flag_b        <= 1'b0;
      o_moves         <= 8'd0;
    end else begin
      state           <= state_nxt;
      pause_side      <= pause_side_nxt;
      o_player_a_stop <= stop_a_nxt;
      o_player_b_stop <= stop_b_nxt;
      o_restart       <= restart_nxt;
      o_flag_a        <= flag_a_nxt;
      o_flag_b        <= flag_b_nxt;
      o_moves         <= moves_nxt;
    end
  end

  // Next-state logic. Priority inside a running state: zero, then stop, then click.
  always_comb begin
    state_nxt      = state;
    pause_side_nxt = pause_side;
    move_a         = 1'b0;
    move_b         = 1'b0;
    flag_a_set     = 1'b0;
    flag_b_set     = 1'b0;
    if (i_restart) begin
      state_nxt = CC_IDLE;
    end else begin
      case (state)
        CC_IDLE: begin
          if (click_a)      state_nxt = CC_RUN_B;
          else if (click_b) state_nxt = CC_RUN_A;
        end
        CC_RUN_A: begin
          if (i_player_a_zero) begin
            state_nxt  = CC_FLAG;
            flag_a_set = 1'b1;
          end else if (i_stop) begin
            state_nxt      = CC_PAUSE;
            pause_side_nxt = 1'b0;
          end else if (click_a) begin
            state_nxt = CC_RUN_B;
            move_a    = 1'b1;
          end
        end
        CC_RUN_B: begin
          if (i_player_b_zero) begin
            state_nxt  = CC_FLAG;
            flag_b_set = 1'b1;
          end else if (i_stop) begin
            state_nxt      = CC_PAUSE;
            pause_side_nxt = 1'b1;
          end else if (click_b) begin
            state_nxt = CC_RUN_A;
            move_b    = 1'b1;
          end
        end
        CC_PAUSE: begin
          if (i_stop) state_nxt = pause_side ? CC_RUN_B : CC_RUN_A;
        end
        CC_FLAG: state_nxt = CC_FLAG;
        default: state_nxt = CC_IDLE;
      endcase
    end
  end

  // Output logic: next values for the registered outputs.
  always_comb begin
    stop_a_nxt  = (state_nxt != CC_RUN_A);
    stop_b_nxt  = (state_nxt != CC_RUN_B);
    restart_nxt = ~i_restart;
    flag_a_nxt  = i_restart ? 1'b0 : (o_flag_a | flag_a_set);
    flag_b_nxt  = i_restart ? 1'b0 : (o_flag_b | flag_b_set);
    moves_nxt   = o_moves;
    if (i_restart) begin
      moves_nxt = 8'd0;
    end else if ((move_a | move_b) && o_moves != 8'hFF) begin
      moves_nxt = o_moves + 8'd1;
    end
  end

  chess_bonus_seq #(.p_INCREMENT(p_INCREMENT)) u_bonus_a (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clear (i_restart),
    .i_add   (move_a),
    .o_plus  (o_plus_a)
  );

  chess_bonus_seq #(.p_INCREMENT(p_INCREMENT)) u_bonus_b (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clear (i_restart),
    .i_add   (move_b),
    .o_plus  (o_plus_b)
  );

endmodule

// File: tb/tb_chess_turn_ctrl.sv
// Self-checking bench for chess_turn_ctrl: directed scenarios with literal expectations,
// then randomized clicks checked every cycle against a behavioural model of the clock.
module tb_chess_turn_ctrl;

  localparam int INC = 2;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_restart = 1'b0;
  logic       i_stop = 1'b0;
  logic       i_player_a = 1'b0;
  logic       i_player_b = 1'b0;
  logic       i_player_a_zero = 1'b0;
  logic       i_player_b_zero = 1'b0;
  logic       o_player_a_stop, o_player_b_stop, o_plus_a, o_plus_b;
  logic       o_restart, o_flag_a, o_flag_b;
  logic [7:0] o_moves;

  always #10 i_clk = ~i_clk;

  chess_turn_ctrl #(.p_INCREMENT(INC)) dut (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .i_restart       (i_restart),
    .i_stop          (i_stop),
    .i_player_a      (i_player_a),
    .i_player_b      (i_player_b),
    .i_player_a_zero (i_player_a_zero),
    .i_player_b_zero (i_player_b_zero),
    .o_player_a_stop (o_player_a_stop),
    .o_player_b_stop (o_player_b_stop),
    .o_plus_a        (o_plus_a),
    .o_plus_b        (o_plus_b),
    .o_restart       (o_restart),
    .o_flag_a        (o_flag_a),
    .o_flag_b        (o_flag_b),
    .o_moves         (o_moves)
  );

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Who is on move (0 nobody, 1 A, 2 B), whether the game is paused or a flag
  // has fallen, plus per-player pending bonus seconds and time of last pulse.
  int m_run = 0;
  bit m_paused = 0, m_flagged = 0, m_flag_a = 0, m_flag_b = 0, m_restart_out = 0;
  int m_moves = 0;
  int m_cyc = 0;
  int m_pend[2] = '{0, 0};
  int m_last[2] = '{-100, -100};
  bit m_plus[2] = '{0, 0};

  task automatic model_clear();
    m_run = 0; m_paused = 0; m_flagged = 0; m_flag_a = 0; m_flag_b = 0;
    m_restart_out = 0; m_moves = 0;
    for (int p = 0; p < 2; p++) begin
      m_pend[p] = 0; m_last[p] = -100; m_plus[p] = 0;
    end
  endtask

  task automatic model_step();
    bit ca, cb;
    int add[2];
    add = '{0, 0};
    m_cyc++;
    if (i_restart) begin
      model_clear();
      return;
    end
    m_restart_out = 1;
    ca = i_player_a && !i_player_b;
    cb = i_player_b && !i_player_a;
    if (m_flagged) begin
      // only restart or reset leaves a fallen flag
    end else if (m_paused) begin
      if (i_stop) m_paused = 0;
    end else if (m_run == 0) begin
      if (ca) m_run = 2;
      else if (cb) m_run = 1;
    end else if (m_run == 1) begin
      if (i_player_a_zero) begin m_flagged = 1; m_flag_a = 1; end
      else if (i_stop) m_paused = 1;
      else if (ca) begin
        m_run = 2;
        m_moves = (m_moves < 255) ? m_moves + 1 : 255;
        add[0] = INC;
      end
    end else begin
      if (i_player_b_zero) begin m_flagged = 1; m_flag_b = 1; end
      else if (i_stop) m_paused = 1;
      else if (cb) begin
        m_run = 1;
        m_moves = (m_moves < 255) ? m_moves + 1 : 255;
        add[1] = INC;
      end
    end
    for (int p = 0; p < 2; p++) begin
      m_pend[p] = (m_pend[p] + add[p] > 15) ? 15 : m_pend[p] + add[p];
      if (m_pend[p] > 0 && (m_cyc - m_last[p]) >= 2) begin
        m_plus[p] = 1;
        m_pend[p]--;
        m_last[p] = m_cyc;
      end else begin
        m_plus[p] = 0;
      end
    end
  endtask

  always @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) model_clear();
    else model_step();
  end

  // Compare process: DUT against model every cycle, away from the active edge.
  always @(negedge i_clk) begin
    if (cmp_en) begin
      chk("m_stop_a", int'(o_player_a_stop), int'(!(m_run == 1 && !m_paused && !m_flagged)));
      chk("m_stop_b", int'(o_player_b_stop), int'(!(m_run == 2 && !m_paused && !m_flagged)));
      chk("m_plus_a", int'(o_plus_a), int'(m_plus[0]));
      chk("m_plus_b", int'(o_plus_b), int'(m_plus[1]));
      chk("m_restart", int'(o_restart), int'(m_restart_out));
      chk("m_flag_a", int'(o_flag_a), int'(m_flag_a));
      chk("m_flag_b", int'(o_flag_b), int'(m_flag_b));
      chk("m_moves", int'(o_moves), m_moves);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive(input bit a, input bit b, input bit stp, input bit rs,
                       input bit za, input bit zb);
    i_player_a = a; i_player_b = b; i_stop = stp; i_restart = rs;
    i_player_a_zero = za; i_player_b_zero = zb;
    tick();
    i_player_a = 0; i_player_b = 0; i_stop = 0; i_restart = 0;
    i_player_a_zero = 0; i_player_b_zero = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    // Reset values while reset is held.
    #5 i_rst = 1'b0;
    cmp_en = 1'b1;
    #1;
    chk("rst_stop_a", int'(o_player_a_stop), 1);
    chk("rst_stop_b", int'(o_player_b_stop), 1);
    chk("rst_restart", int'(o_restart), 0);
    chk("rst_moves", int'(o_moves), 0);
    chk("rst_flags", int'({o_flag_a, o_flag_b}), 0);
    repeat (2) tick();
    i_rst = 1'b1;
    tick();
    chk("rst_release_restart", int'(o_restart), 1);

    // IDLE, A clicks: B's clock starts, no move, no bonus.
    drive(1, 0, 0, 0, 0, 0);
    chk("s1_stop_b", int'(o_player_b_stop), 0);
    chk("s1_stop_a", int'(o_player_a_stop), 1);
    chk("s1_moves", int'(o_moves), 0);
    chk("s1_plus", int'({o_plus_a, o_plus_b}), 0);
    repeat (3) begin
      tick();
      chk("s1_plus_later", int'({o_plus_a, o_plus_b}), 0);
    end

    // RUN_B, B moves: bonus pulses at +1 and +3 only.
    drive(0, 1, 0, 0, 0, 0);
    chk("s2_stop_a", int'(o_player_a_stop), 0);
    chk("s2_moves", int'(o_moves), 1);
    chk("s2_plus_b_p1", int'(o_plus_b), 1);
    chk("s2_model_moves", m_moves, 1);
    tick(); chk("s2_plus_b_p2", int'(o_plus_b), 0);
    tick(); chk("s2_plus_b_p3", int'(o_plus_b), 1);
    tick(); chk("s2_plus_b_p4", int'(o_plus_b), 0);
    tick(); chk("s2_plus_b_p5", int'(o_plus_b), 0);

    // RUN_A: pause, click ignored while paused, resume with a same-cycle click.
    drive(0, 0, 1, 0, 0, 0);
    chk("s3_pause_stops", int'({o_player_a_stop, o_player_b_stop}), 3);
    drive(1, 0, 0, 0, 0, 0);
    chk("s3_pause_click_stops", int'({o_player_a_stop, o_player_b_stop}), 3);
    chk("s3_pause_click_moves", int'(o_moves), 1);
    drive(1, 0, 1, 0, 0, 0);
    chk("s3_resume_stops", int'({o_player_a_stop, o_player_b_stop}), 1);
    chk("s3_resume_moves", int'(o_moves), 1);
    chk("s3_resume_plus_a", int'(o_plus_a), 0);

    // RUN_A: zero wins over same-cycle click; later clicks ignored.
    drive(1, 0, 0, 0, 1, 0);
    chk("s4_flag_a", int'(o_flag_a), 1);
    chk("s4_stops", int'({o_player_a_stop, o_player_b_stop}), 3);
    chk("s4_moves", int'(o_moves), 1);
    chk("s4_plus_a", int'(o_plus_a), 0);
    drive(0, 1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0);
    chk("s4_flag_hold", int'(o_flag_a), 1);
    chk("s4_moves_hold", int'(o_moves), 1);
    chk("s4_stops_hold", int'({o_player_a_stop, o_player_b_stop}), 3);

    // FLAG, restart.
    drive(0, 0, 0, 1, 0, 0);
    chk("s5_restart_low", int'(o_restart), 0);
    chk("s5_flags", int'({o_flag_a, o_flag_b}), 0);
    chk("s5_moves", int'(o_moves), 0);
    tick();
    chk("s5_restart_high", int'(o_restart), 1);

    // Restart after first of two bonus pulses aborts the second.
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0);
    chk("s6_plus_b_first", int'(o_plus_b), 1);
    drive(0, 0, 0, 1, 0, 0);
    chk("s6_plus_b_p2", int'(o_plus_b), 0);
    tick(); chk("s6_plus_b_p3", int'(o_plus_b), 0);
    tick(); chk("s6_plus_b_p4", int'(o_plus_b), 0);

    // 256 alternating moves: count saturates at 255.
    drive(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 256; k++) begin
      if (k % 2 == 0) drive(0, 1, 0, 0, 0, 0);
      else drive(1, 0, 0, 0, 0, 0);
      if (k == 99) chk("s7_moves_100", int'(o_moves), 100);
    end
    chk("s7_moves_sat", int'(o_moves), 255);
    chk("s7_model_moves_sat", m_moves, 255);
    drive(0, 0, 0, 1, 0, 0);

    // Randomized phase, with one asynchronous reset in the middle.
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        i_rst = 1'b0;
        repeat (2) tick();
        i_rst = 1'b1;
      end
      i_player_a      = ($urandom_range(0, 99) < 30);
      i_player_b      = ($urandom_range(0, 99) < 30);
      i_stop          = ($urandom_range(0, 99) < 6);
      i_restart       = ($urandom_range(0, 199) < 2);
      i_player_a_zero = ($urandom_range(0, 99) < 3);
      i_player_b_zero = ($urandom_range(0, 99) < 3);
      tick();
    end
    i_player_a = 0; i_player_b = 0; i_stop = 0; i_restart = 0;
    i_player_a_zero = 0; i_player_b_zero = 0;
    repeat (4) tick();
    @(negedge i_clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
